// File: rtl/fp_mul_pkg.sv
// Shared types and constant helpers for the pipelined floating-point multiplier.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_e;

  // Undefined encodings fall back to round-to-nearest-even.
  function automatic rmode_e decode_rmode(input logic [2:0] raw);
    rmode_e m;
    case (raw)
      3'b001:  m = RM_RTZ;
      3'b010:  m = RM_RDN;
      3'b011:  m = RM_RUP;
      3'b100:  m = RM_RMM;
      default: m = RM_RNE;
    endcase
    return m;
  endfunction

  // Bit patterns below are returned 64 bits wide; callers keep the low FP_W bits.
  function automatic logic [63:0] inf_bits(input int exp_w, input int frc_w);
    return ((64'd1 << exp_w) - 64'd1) << frc_w;
  endfunction

  function automatic logic [63:0] canon_nan(input int exp_w, input int frc_w);
    return inf_bits(exp_w, frc_w) | (64'd1 << (frc_w - 1));
  endfunction

  function automatic logic [63:0] max_finite(input int exp_w, input int frc_w);
    return (((64'd1 << exp_w) - 64'd2) << frc_w) | ((64'd1 << frc_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
);
  localparam int FP_W = 1 + EXP_W + FRC_W;

  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] fp_X;
  logic [FP_W-1:0] fp_Y;
  logic [2:0]      r_mode;
  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] fp_Z;
  logic            ovrf;
  logic            udrf;

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf
  );

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf
  );
endinterface

// File: rtl/fp_round.sv
// Normalises the raw significand product, rounds it per mode and resolves
// overflow/underflow into the packed result.
module fp_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                    sign,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic [2*FRC_W+1:0]      prod,
  input  rmode_e                  rm,
  output logic [EXP_W+FRC_W:0]    result,
  output logic                    ovrf,
  output logic                    udrf
);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(1);
  localparam logic [63:0] INF64 = inf_bits(EXP_W, FRC_W);
  localparam logic [63:0] MAX64 = max_finite(EXP_W, FRC_W);

  logic                 hi;
  logic [FRC_W:0]       mant;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic                 carry;
  logic [FRC_W+1:0]     mant_r;
  logic [FRC_W-1:0]     frac;
  logic signed [XW-1:0] exp_n;
  logic signed [XW-1:0] exp_r;
  logic [EXP_W+FRC_W:0] inf_res;
  logic [EXP_W+FRC_W:0] max_res;

  // Product lies in [1,4); the top bit says whether it reached 2.
  assign hi = prod[2*FRC_W+1];

  always_comb begin
    if (hi) begin
      mant   = prod[2*FRC_W+1:FRC_W+1];
      guard  = prod[FRC_W];
      sticky = |prod[FRC_W-1:0];
    end else begin
      mant   = prod[2*FRC_W:FRC_W];
      guard  = prod[FRC_W-1];
      sticky = |prod[FRC_W-2:0];
    end
  end

  assign exp_n = exp_in + $signed({{(XW-1){1'b0}}, hi});

  always_comb begin
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      RM_RUP:  inc = ~sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase
  end

  // A carry out of the rounded significand means it became exactly 2.0.
  assign mant_r = {1'b0, mant} + {{(FRC_W+1){1'b0}}, inc};
  assign carry  = mant_r[FRC_W+1];
  assign frac   = carry ? mant_r[FRC_W:1] : mant_r[FRC_W-1:0];
  assign exp_r  = exp_n + $signed({{(XW-1){1'b0}}, carry});

  assign ovrf = (exp_r >= EXP_MAX);
  assign udrf = (exp_r < EXP_MIN);

  assign inf_res = {sign, INF64[EXP_W+FRC_W-1:0]};
  assign max_res = {sign, MAX64[EXP_W+FRC_W-1:0]};

  always_comb begin
    result = {sign, exp_r[EXP_W-1:0], frac};
    if (ovrf) begin
      case (rm)
        RM_RTZ:  result = max_res;
        RM_RDN:  result = sign ? inf_res : max_res;
        RM_RUP:  result = sign ? max_res : inf_res;
        default: result = inf_res;
      endcase
    end else if (udrf) begin
      result = {sign, {(EXP_W+FRC_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control;
// a stalled output freezes the whole pipe.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_pipe_if.slave bus
);
  localparam int FP_W = 1 + EXP_W + FRC_W;
  localparam int XW   = EXP_W + 2;
  localparam int MW   = FRC_W + 1;
  localparam int PW   = 2 * MW;
  localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [63:0] NAN64 = canon_nan(EXP_W, FRC_W);
  localparam logic [63:0] INF64 = inf_bits(EXP_W, FRC_W);

  logic advance;

  // ---------------- S1: unpack, classify, exponent sum ----------------
  logic [FP_W-1:0]  op  [2];
  logic             sgn [2];
  logic [EXP_W-1:0] ex  [2];
  logic [FRC_W-1:0] fr  [2];
  logic [MW-1:0]    man [2];
  fclass_e          cls [2];

  assign op[0] = bus.fp_X;
  assign op[1] = bus.fp_Y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign sgn[gi] = op[gi][FP_W-1];
      assign ex[gi]  = op[gi][FP_W-2 -: EXP_W];
      assign fr[gi]  = op[gi][FRC_W-1:0];
      assign man[gi] = {1'b1, fr[gi]};
      // Subnormals (exp==0) are flushed to zero here.
      assign cls[gi] = (ex[gi] == '0) ? CLS_ZERO :
                       (&ex[gi])      ? ((fr[gi] == '0) ? CLS_INF : CLS_NAN) :
                                        CLS_NORM;
    end
  endgenerate

  fclass_e              s1_cls_next;
  logic signed [XW-1:0] s1_exp_next;

  always_comb begin
    if (cls[0] == CLS_NAN || cls[1] == CLS_NAN ||
        (cls[0] == CLS_ZERO && cls[1] == CLS_INF) ||
        (cls[0] == CLS_INF && cls[1] == CLS_ZERO))
      s1_cls_next = CLS_NAN;
    else if (cls[0] == CLS_INF || cls[1] == CLS_INF)
      s1_cls_next = CLS_INF;
    else if (cls[0] == CLS_ZERO || cls[1] == CLS_ZERO)
      s1_cls_next = CLS_ZERO;
    else
      s1_cls_next = CLS_NORM;
  end

  assign s1_exp_next = $signed({2'b00, ex[0]}) + $signed({2'b00, ex[1]}) - BIAS_X;

  logic                 s1_valid_reg;
  logic                 s1_sign_reg;
  fclass_e              s1_cls_reg;
  logic signed [XW-1:0] s1_exp_reg;
  logic [MW-1:0]        s1_ma_reg;
  logic [MW-1:0]        s1_mb_reg;
  rmode_e               s1_rm_reg;

  // ---------------- S2: significand product ----------------
  logic                 s2_valid_reg;
  logic                 s2_sign_reg;
  fclass_e              s2_cls_reg;
  logic signed [XW-1:0] s2_exp_reg;
  logic [PW-1:0]        s2_prod_reg;
  rmode_e               s2_rm_reg;
  logic [PW-1:0]        s2_prod_next;

  assign s2_prod_next = PW'(s1_ma_reg) * PW'(s1_mb_reg);

  // ---------------- S3: round, resolve specials, pack ----------------
  logic [FP_W-1:0] rnd_result;
  logic            rnd_ovrf;
  logic            rnd_udrf;
  logic [FP_W-1:0] z_next;
  logic            ovrf_next;
  logic            udrf_next;

  fp_round #(
    .EXP_W (EXP_W),
    .FRC_W (FRC_W)
  ) u_round (
    .sign   (s2_sign_reg),
    .exp_in (s2_exp_reg),
    .prod   (s2_prod_reg),
    .rm     (s2_rm_reg),
    .result (rnd_result),
    .ovrf   (rnd_ovrf),
    .udrf   (rnd_udrf)
  );

  always_comb begin
    z_next    = '0;
    ovrf_next = 1'b0;
    udrf_next = 1'b0;
    if (s2_valid_reg) begin
      case (s2_cls_reg)
        CLS_NAN:  z_next = NAN64[FP_W-1:0];
        CLS_INF:  z_next = {s2_sign_reg, INF64[FP_W-2:0]};
        CLS_ZERO: z_next = {s2_sign_reg, {(FP_W-1){1'b0}}};
        default: begin
          z_next    = rnd_result;
          ovrf_next = rnd_ovrf;
          udrf_next = rnd_udrf;
        end
      endcase
    end
  end

  logic            out_valid_reg;
  logic [FP_W-1:0] fp_z_reg;
  logic            ovrf_reg;
  logic            udrf_reg;

  assign advance       = !(out_valid_reg && !bus.out_ready);
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_reg;
  assign bus.fp_Z      = fp_z_reg;
  assign bus.ovrf      = ovrf_reg;
  assign bus.udrf      = udrf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      fp_z_reg      <= '0;
      ovrf_reg      <= 1'b0;
      udrf_reg      <= 1'b0;
    end else if (advance) begin
      s1_valid_reg  <= bus.in_valid;
      s2_valid_reg  <= s1_valid_reg;
      out_valid_reg <= s2_valid_reg;
      fp_z_reg      <= z_next;
      ovrf_reg      <= ovrf_next;
      udrf_reg      <= udrf_next;
    end
  end

  // Datapath registers need no reset: they are qualified by the stage valids.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign_reg <= sgn[0] ^ sgn[1];
      s1_cls_reg  <= s1_cls_next;
      s1_exp_reg  <= s1_exp_next;
      s1_ma_reg   <= man[0];
      s1_mb_reg   <= man[1];
      s1_rm_reg   <= decode_rmode(bus.r_mode);
      s2_sign_reg <= s1_sign_reg;
      s2_cls_reg  <= s1_cls_reg;
      s2_exp_reg  <= s1_exp_reg;
      s2_prod_reg <= s2_prod_next;
      s2_rm_reg   <= s1_rm_reg;
    end
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter FRC_W, default 23, meaning fraction field width; FP_W = 1+EXP_W+FRC_W, BIAS = 2^(EXP_W-1)-1.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 fp_X, fp_Y  input  FP_W  IEEE-754-style operands {sign, exp, frac}.
REQ-008 r_mode  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 fp_Z  output  FP_W  product.
REQ-012 ovrf, udrf  output  1 each  overflow / underflow flags, qualified by out_valid.

Function
REQ-013 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output); r_mode is sampled with the operands.
REQ-014 Three stages: S1 unpack/classify/exponent sum; S2 (FRC_W+1)x(FRC_W+1) significand product; S3 normalise/round/pack/flags.
REQ-015 Latency: an accepted operand pair SHALL produce out_valid exactly 3 cycles later when unstalled; throughput one per cycle.
REQ-016 Stall: when out_valid && !out_ready, all stages SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1 (bubbles advance).
REQ-017 Outputs SHALL remain stable while out_valid && !out_ready; results SHALL emerge in acceptance order with no loss or duplication.
REQ-018 Subnormal inputs (exp==0) SHALL be treated as zero of the same sign; this flush alone SHALL NOT set udrf.
REQ-019 Result sign SHALL be sign(X) xor sign(Y) for all non-NaN results, including zero.
REQ-020 NaN input, or zero(incl. flushed subnormal) x inf, SHALL give canonical NaN {0, all-ones exp, frac MSB 1, rest 0}, flags 0.
REQ-021 inf x finite-nonzero or inf x inf SHALL give signed inf, flags 0; zero x finite SHALL give signed zero, flags 0.
REQ-022 Rounding SHALL use guard and sticky bits of the full product per r_mode; mantissa carry-out after rounding SHALL renormalise (exp+1).
REQ-023 r_mode values 101-111 SHALL behave as RNE.
REQ-024 Overflow (rounded biased exp >= 2^EXP_W-1) SHALL set ovrf=1 and give: RNE/RMM +-inf; RTZ +-max finite; RDN +max/-inf; RUP +inf/-max.
REQ-025 Underflow (rounded biased exp < 1, nonzero product) SHALL set udrf=1 and give signed zero; no subnormal output is ever produced.
REQ-026 Exponent arithmetic SHALL be carried at EXP_W+2 bits signed to avoid wrap.

Reset
REQ-027 While rst is high at a clock edge, all stage valids, out_valid, fp_Z, ovrf, udrf SHALL be 0 next cycle; in-flight operations are discarded.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-029 Package fp_mul_pkg SHALL hold the r_mode enum, the operand-class enum (ZERO, NORM, INF, NAN), and canonical-NaN/max-finite constant functions of EXP_W/FRC_W.
REQ-030 Normalise+round+overflow/underflow logic SHALL be sub-module fp_round, instantiated in S3.

Verification (EXP_W=8, FRC_W=23)
REQ-031 0x3FC00000 x 0x40000000, RNE -> 0x40400000, flags 0, out_valid 3 cycles after accept.
REQ-032 0x80400000 x 0x3F800000 -> 0x80000000, udrf=0; 0x00800000 x 0x3F000000 -> 0x00000000, udrf=1.
REQ-033 0x7F000000 x 0x40000000: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, ovrf=1 both; 0xFF000000 x 0x40000000 RUP -> 0xFF7FFFFF.
REQ-034 0x7F800000 x 0x00000000 -> 0x7FC00000, flags 0.
REQ-035 Four back-to-back inputs with out_ready low 5 cycles -> in_ready drops while stalled, all four results delivered in order, fp_Z stable during stall.
REQ-036 rst pulsed with two operations in flight -> out_valid=0 next cycle, no stale result ever appears.
